// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module : calc_pkg
// Brief  : Op codes, FSM state encoding and width default shared by the
//          keypad calculator blocks.
// Rev    : 1.0
// ============================================================================
package calc_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [3:0] OP_ADD = 4'hA;
    localparam logic [3:0] OP_SUB = 4'hB;
    localparam logic [3:0] OP_MUL = 4'hC;
    localparam logic [3:0] OP_DIV = 4'hD;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/calc_iter_step.sv
`default_nettype none
// ============================================================================
// Module : calc_iter_step
// Brief  : One combinational mul (shift-add) or div (restoring) iteration.
// Rev    : 1.0
// ============================================================================
module calc_iter_step
    import calc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               i_mode,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_operand,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_trial;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem;

    // Mul: acc = {partial, multiplier}; acc[0] is the current multiplier bit.
    // Div: acc = {remainder, dividend/quotient}; quotient shifts in at LSB.
    always_comb begin
        w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
                + (i_acc[0] ? {1'b0, i_operand} : '0);
        w_trial = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
        w_qbit  = (w_trial >= {1'b0, i_operand});
        w_rem   = w_qbit ? (w_trial[WIDTH-1:0] - i_operand) : w_trial[WIDTH-1:0];
        if (i_mode) begin
            o_acc = {w_rem, i_acc[WIDTH-2:0], w_qbit};
        end else begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end
    end

endmodule : calc_iter_step
`default_nettype wire

// File: rtl/calc_alu_seq.sv
`default_nettype none
// ============================================================================
// Module : calc_alu_seq
// Brief  : Multi-cycle add/sub/mul/div sequencer with start/done handshake.
// Rev    : 1.0
// ============================================================================
module calc_alu_seq
    import calc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             div_zero,
    output logic             bad_op
);

    localparam int                 c_cnt_w = $clog2(ITER);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(ITER - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_result;
    logic               r_ovf;
    logic               r_div_zero;
    logic               r_bad_op;
    logic               r_done;

    logic               w_div_mode;
    logic [WIDTH:0]     w_add;
    logic [2*WIDTH-1:0] w_step;
    logic               w_last;

    assign w_div_mode = (r_op == OP_DIV);
    assign w_add      = {1'b0, r_a} + {1'b0, r_b};
    assign w_last     = (r_cnt == c_last);

    calc_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_mode    (w_div_mode),
        .i_acc     (r_acc),
        .i_operand (w_div_mode ? r_b : r_a),
        .o_acc     (w_step)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_result   <= '0;
            r_ovf      <= 1'b0;
            r_div_zero <= 1'b0;
            r_bad_op   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_a     <= a;
                        r_b     <= b;
                        r_cnt   <= '0;
                        // Dividend for div, multiplier for everything else.
                        r_acc   <= {{WIDTH{1'b0}}, (op == OP_DIV) ? a : b};
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    case (r_op)
                        OP_ADD: begin
                            r_result   <= w_add[WIDTH-1:0];
                            r_ovf      <= w_add[WIDTH];
                            r_div_zero <= 1'b0;
                            r_bad_op   <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= ST_DONE;
                        end
                        OP_SUB: begin
                            r_result   <= r_a - r_b;
                            r_ovf      <= (r_a < r_b);
                            r_div_zero <= 1'b0;
                            r_bad_op   <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= ST_DONE;
                        end
                        OP_MUL: begin
                            r_acc <= w_step;
                            r_cnt <= r_cnt + c_one;
                            if (w_last) begin
                                r_result   <= w_step[WIDTH-1:0];
                                r_ovf      <= |w_step[2*WIDTH-1:WIDTH];
                                r_div_zero <= 1'b0;
                                r_bad_op   <= 1'b0;
                                r_done     <= 1'b1;
                                r_state    <= ST_DONE;
                            end
                        end
                        OP_DIV: begin
                            if (r_b == '0) begin
                                r_result   <= '1;
                                r_ovf      <= 1'b0;
                                r_div_zero <= 1'b1;
                                r_bad_op   <= 1'b0;
                                r_done     <= 1'b1;
                                r_state    <= ST_DONE;
                            end else begin
                                r_acc <= w_step;
                                r_cnt <= r_cnt + c_one;
                                if (w_last) begin
                                    r_result   <= w_step[WIDTH-1:0];
                                    r_ovf      <= 1'b0;
                                    r_div_zero <= 1'b0;
                                    r_bad_op   <= 1'b0;
                                    r_done     <= 1'b1;
                                    r_state    <= ST_DONE;
                                end
                            end
                        end
                        default: begin
                            r_ovf      <= 1'b0;
                            r_div_zero <= 1'b0;
                            r_bad_op   <= 1'b1;
                            r_done     <= 1'b1;
                            r_state    <= ST_DONE;
                        end
                    endcase
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign result   = r_result;
    assign ovf      = r_ovf;
    assign div_zero = r_div_zero;
    assign bad_op   = r_bad_op;

endmodule : calc_alu_seq
`default_nettype wire

// File: tb/tb_calc_alu_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_calc_alu_seq
// Brief  : Self-checking bench for calc_alu_seq (vector table, random ops,
//          busy-start and mid-operation reset sequences).
// Rev    : 1.0
// ============================================================================
module tb_calc_alu_seq;
    import calc_pkg::*;

    localparam int W = 16;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         ovf;
        logic         dz;
        logic         bad;
        int           lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         ovf;
    logic         div_zero;
    logic         bad_op;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    calc_alu_seq #(
        .WIDTH (W),
        .ITER  (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .ovf      (ovf),
        .div_zero (div_zero),
        .bad_op   (bad_op)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] o, input int x, input int y, input int r,
                                input logic v, input logic z, input logic q, input int l);
        vec_t t;
        t.op = o; t.a = W'(x); t.b = W'(y); t.res = W'(r);
        t.ovf = v; t.dz = z; t.bad = q; t.lat = l;
        return t;
    endfunction

    // Reference: plain integer arithmetic; latency counted in edges after start is sampled.
    function automatic vec_t model(input logic [3:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic [W-1:0] prev);
        vec_t        t;
        longint      s;
        t.op = o; t.a = x; t.b = y; t.res = prev;
        t.ovf = 1'b0; t.dz = 1'b0; t.bad = 1'b0; t.lat = 1;
        case (o)
            OP_ADD: begin
                s = longint'(x) + longint'(y);
                t.res = W'(s % 65536);
                t.ovf = (s > 65535);
            end
            OP_SUB: begin
                s = longint'(x) - longint'(y) + 65536;
                t.res = W'(s % 65536);
                t.ovf = (x < y);
            end
            OP_MUL: begin
                s = longint'(x) * longint'(y);
                t.res = W'(s % 65536);
                t.ovf = (s >= 65536);
                t.lat = W;
            end
            OP_DIV: begin
                if (y == 0) begin
                    t.res = '1;
                    t.dz  = 1'b1;
                end else begin
                    t.res = W'(longint'(x) / longint'(y));
                    t.lat = W;
                end
            end
            default: t.bad = 1'b1;
        endcase
        return t;
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        start = 1'b1; op = v.op; a = v.a; b = v.b;
        @(posedge clk); #1;
        check({tag, " busy_rise"}, 32'(busy), 32'd1);
        start = 1'b0; op = 4'($urandom); a = W'($urandom); b = W'($urandom);
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(posedge clk); #1;
            if (done) lat = c;
        end
        check({tag, " latency"}, 32'(lat), 32'(v.lat));
        check({tag, " result"}, 32'(result), 32'(v.res));
        check({tag, " flags"}, {29'd0, ovf, div_zero, bad_op}, {29'd0, v.ovf, v.dz, v.bad});
        @(posedge clk); #1;
        check({tag, " idle"}, {30'd0, busy, done}, 32'd0);
        check({tag, " hold"}, 32'(result), 32'(v.res));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl[8];
        vec_t         v;
        logic [W-1:0] last_res;
        logic [3:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           r;
        int           ndone;

        tbl[0] = mk(OP_ADD, 12,    34,  46,    1'b0, 1'b0, 1'b0, 1);
        tbl[1] = mk(OP_ADD, 65535, 1,   0,     1'b1, 1'b0, 1'b0, 1);
        tbl[2] = mk(OP_SUB, 3,     5,   65534, 1'b1, 1'b0, 1'b0, 1);
        tbl[3] = mk(OP_MUL, 123,   45,  5535,  1'b0, 1'b0, 1'b0, 16);
        tbl[4] = mk(OP_MUL, 300,   300, 24464, 1'b1, 1'b0, 1'b0, 16);
        tbl[5] = mk(OP_DIV, 1000,  7,   142,   1'b0, 1'b0, 1'b0, 16);
        tbl[6] = mk(OP_DIV, 5,     0,   65535, 1'b0, 1'b1, 1'b0, 1);
        tbl[7] = mk(4'h3,   77,    88,  65535, 1'b0, 1'b0, 1'b1, 1);

        rst = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {26'd0, busy, done, ovf, div_zero, bad_op, 1'b0}, 32'd0);
        check("reset result", 32'(result), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i], $sformatf("vec%0d", i));
        end
        last_res = tbl[7].res;

        // Start pulsed while a multiply is running must be dropped.
        @(negedge clk);
        start = 1'b1; op = OP_MUL; a = 16'd2; b = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
            if (c == 4) begin
                start = 1'b1; op = OP_ADD; a = 16'd9; b = 16'd9;
            end
            if (c == 5) start = 1'b0;
        end
        check("busy_start done_count", 32'(ndone), 32'd1);
        check("busy_start result", 32'(result), 32'd6);
        check("busy_start idle", 32'(busy), 32'd0);

        // Reset in the middle of a divide.
        run_op(mk(OP_ADD, 12, 34, 46, 1'b0, 1'b0, 1'b0, 1), "pre_reset");
        @(negedge clk);
        start = 1'b1; op = OP_DIV; a = 16'd1000; b = 16'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_reset flags", {27'd0, busy, done, ovf, div_zero, bad_op}, 32'd0);
        check("mid_reset result", 32'(result), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check("mid_reset no_activity", 32'(ndone), 32'd0);
        run_op(mk(OP_ADD, 1, 1, 2, 1'b0, 1'b0, 1'b0, 1), "post_reset");
        last_res = 16'd2;

        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 9));
            x = W'($urandom);
            y = W'($urandom);
            if ($urandom_range(0, 7) == 0) x = '1;
            if ($urandom_range(0, 7) == 0) y = W'($urandom_range(0, 3));
            case (r)
                0, 1:    o = OP_ADD;
                2, 3:    o = OP_SUB;
                4, 5:    o = OP_MUL;
                6, 7:    o = OP_DIV;
                8:       o = 4'($urandom_range(0, 9));
                default: begin o = OP_DIV; y = '0; end
            endcase
            v = model(o, x, y, last_res);
            run_op(v, $sformatf("rnd%0d op=%0h a=%0d b=%0d", i, o, x, y));
            last_res = v.res;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_calc_alu_seq
`default_nettype wire
